inv_round_key_gen: RTL

Sequential AES-128 round-key generator for the decrypt datapath. It expands a 128-bit cipher key forward to the round-10 key. It then streams round keys in decryption order (10 down to 0), one per request, to the AddRoundKey stage that consumes the inv_sub_bytes output. It inverts the key schedule on the fly, so only two 128-bit key registers are needed instead of eleven.

---
 rtl/aes_dec_pkg.sv | 43 ++++
 rtl/inv_round_key_gen_if.sv | 25 ++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_sub_word.sv | 17 +
 rtl/inv_round_key_gen.sv | 119 +++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES decrypt key path.
// Holds the key/word typedefs, FSM state enum, NR, RCON_LAST, xtime, rcon_inv, gf_mul, rot_word.
package aes_dec_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] key_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      SERVE
   } state_t;

   localparam int unsigned NR        = 10;
   localparam logic [7:0]  RCON_LAST = 8'h36;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Walks rcon backwards; 0x1b is the only step whose predecessor overflowed.
   function automatic logic [7:0] rcon_inv(input logic [7:0] r);
      return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/inv_round_key_gen_if.sv
// Bus between the decrypt key generator and its driver / AddRoundKey consumer.
// master drives key_load/key_in/rk_req; slave drives busy/rk_valid/rk_out/rk_idx/rk_last.
interface inv_round_key_gen_if;
   import aes_dec_pkg::*;

   logic       key_load;
   key_t       key_in;
   logic       rk_req;
   logic       busy;
   logic       rk_valid;
   key_t       rk_out;
   logic [3:0] rk_idx;
   logic       rk_last;

   modport master (
      output key_load, key_in, rk_req,
      input  busy, rk_valid, rk_out, rk_idx, rk_last
   );

   modport slave (
      input  key_load, key_in, rk_req,
      output busy, rk_valid, rk_out, rk_idx, rk_last
   );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, computed as GF(2^8) inverse (x^254) followed by the affine map.
// Ports: a_i byte in, s_o substituted byte out.
module aes_sbox
   import aes_dec_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   logic [7:0] inv;
   logic [7:0] sq;

   always_comb begin
      // x^(2+4+...+128) = x^254 = x^-1, with 0 mapping to 0
      inv = 8'h01;
      sq  = a_i;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      s_o = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
   end

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord built from four forward S-box instances.
// Ports: w_i word in, w_o byte-wise substituted word out.
module aes_sub_word
   import aes_dec_pkg::*;
(
   input  word_t w_i,
   output word_t w_o
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (w_i[8*g +: 8]),
         .s_o (w_o[8*g +: 8])
      );
   end

endmodule

// File: rtl/inv_round_key_gen.sv
// AES-128 decrypt round-key generator: expands forward to round 10, then walks back on request.
// Ports: clk, rst (sync, active-high), bus (slave: key_load/key_in/rk_req in, busy/rk_* out).
module inv_round_key_gen
   import aes_dec_pkg::*;
(
   input logic               clk,
   input logic               rst,
   inv_round_key_gen_if.slave bus
);

   state_t     state_q, state_d;
   key_t       cur_key_q, cur_key_d;
   key_t       saved_q, saved_d;
   logic [7:0] rcon_q, rcon_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;

   word_t w0, w1, w2, w3;
   word_t sw_in, sw_out;
   word_t n0, n1, n2, n3;
   word_t p0, p1, p2, p3;
   key_t  fwd_key, inv_key;

   assign w0 = cur_key_q[127:96];
   assign w1 = cur_key_q[95:64];
   assign w2 = cur_key_q[63:32];
   assign w3 = cur_key_q[31:0];

   // One SubWord serves both directions; SERVE needs the
   // recovered previous w3 (w3^w2), EXPAND needs w3 itself.
   assign p3 = w3 ^ w2;
   assign sw_in = (state_q == SERVE) ? rot_word(p3)
                                     : rot_word(w3);

   aes_sub_word u_sub_word (
      .w_i (sw_in),
      .w_o (sw_out)
   );

   assign n0 = w0 ^ sw_out ^ {rcon_q, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign fwd_key = {n0, n1, n2, n3};

   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign p0 = w0 ^ sw_out ^ {rcon_q, 24'h0};
   assign inv_key = {p0, p1, p2, p3};

   always_comb begin
      state_d   = state_q;
      cur_key_d = cur_key_q;
      saved_d   = saved_q;
      rcon_d    = rcon_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      if (bus.key_load) begin
         cur_key_d = bus.key_in;
         rcon_d    = 8'h01;
         cnt_d     = 4'd0;
         state_d   = EXPAND;
      end else begin
         unique case (state_q)
            IDLE: ;
            EXPAND: begin
               cur_key_d = fwd_key;
               rcon_d    = xtime(rcon_q);
               cnt_d     = cnt_q + 4'd1;
               if (cnt_q == 4'(NR - 1)) begin
                  state_d = SERVE;
                  saved_d = fwd_key;
                  rcon_d  = RCON_LAST;
                  idx_d   = 4'(NR);
               end
            end
            SERVE: begin
               if (bus.rk_req) begin
                  if (idx_q != 4'd0) begin
                     cur_key_d = inv_key;
                     idx_d     = idx_q - 4'd1;
                     rcon_d    = rcon_inv(rcon_q);
                  end else begin
                     cur_key_d = saved_q;
                     idx_d     = 4'(NR);
                     rcon_d    = RCON_LAST;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_key_q <= '0;
         saved_q   <= '0;
         rcon_q    <= 8'h00;
         cnt_q     <= 4'd0;
         idx_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         cur_key_q <= cur_key_d;
         saved_q   <= saved_d;
         rcon_q    <= rcon_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.busy     = (state_q == EXPAND);
   assign bus.rk_valid = (state_q == SERVE);
   assign bus.rk_out   = bus.rk_valid ? cur_key_q : '0;
   assign bus.rk_idx   = bus.rk_valid ? idx_q : 4'd0;
   assign bus.rk_last  = bus.rk_valid && (idx_q == 4'd0);

endmodule
